// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment scan display.
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF: segment patterns {g,f,e,d,c,b,a} in
//     active-high form, so a 1 means the segment is lit.
//   - scan_state_t: the two scan states, GAP and DRIVE.
//   - calc_div(): the number of clocks each digit slot lasts.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic {
      GAP   = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // A full frame visits every digit once, so each slot lasts
   // clk / (refresh * digits) clocks.
   function automatic int calc_div(input int clk_hz, input int refresh_hz,
                                   input int n_digits);
      return clk_hz / (refresh_hz * n_digits);
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: the signals between the BCD counter chain and the
// display pins.
//   DIGITS : packed BCD value; digit 0 is in [3:0] and is the rightmost digit
//   LOAD   : capture request for DIGITS
//   SEGS   : segment drive {g,f,e,d,c,b,a}
//   AN     : digit enables
//   FRAME  : one-cycle pulse at the start of every scan frame
// Modport master belongs to the producer of DIGITS; modport slave belongs to
// the display driver.
interface seg7_scan_display_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] DIGITS;
   logic                  LOAD;
   logic [6:0]            SEGS;
   logic [N_DIGITS-1:0]   AN;
   logic                  FRAME;

   modport master (output DIGITS, LOAD, input SEGS, AN, FRAME);
   modport slave  (input DIGITS, LOAD, output SEGS, AN, FRAME);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble-to-segment decoder.
//   digit : BCD nibble. Values 10..15 decode to a dash.
//   segs  : pattern {g,f,e,d,c,b,a} at pin polarity, inverted when ACTIVE_LOW=1.
module bcd_to_seg7
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit,
   output logic [6:0] segs
);

   logic [6:0] pattern;

   always_comb begin
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
      segs = ACTIVE_LOW ? ~pattern : pattern;
   end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed N-digit common-anode seven-segment
// driver. It contains a refresh prescaler, a GAP/DRIVE scan FSM, a tear-free
// snapshot of the incoming value, and registered outputs.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : seg7_scan_display_if.slave (DIGITS, LOAD in; SEGS, AN, FRAME out)
// Optional macro LEADING_ZERO_BLANK_EN blanks the digits above the
// most-significant nonzero digit. Those digits are still scanned, but their
// segments stay off.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int REFRESH_HZ  = 1000,
   parameter int N_DIGITS    = 4,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST,
   seg7_scan_display_if.slave   bus
);

   localparam int DIV   = calc_div(CLK_FREQ_HZ, REFRESH_HZ, N_DIGITS);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [6:0]          SEG_PINS_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [N_DIGITS-1:0] AN_PINS_OFF  = {N_DIGITS{ACTIVE_LOW}};

   if (DIV < 2) begin : g_div_check
      $error("seg7_scan_display: slot length DIV must be at least 2");
   end
   if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_ndig_check
      $error("seg7_scan_display: N_DIGITS must be in 1..8");
   end

   logic [CNT_W-1:0]      presc_cnt;
   logic                  tick;
   scan_state_t           state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic                  wrap;
   logic [4*N_DIGITS-1:0] display, pending;
   logic                  pend_flag;
   logic [3:0]            cur_digit;
   logic                  cur_blank;
   logic [6:0]            dec_segs;
   logic [N_DIGITS-1:0]   an_sel;
   logic [6:0]            segs_p1;
   logic [N_DIGITS-1:0]   an_p1;
   logic                  frame_p1;

   // ---- prescaler: one tick per digit slot ----
   assign tick = (presc_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       presc_cnt <= '0;
      else if (tick) presc_cnt <= '0;
      else           presc_cnt <= presc_cnt + CNT_W'(1);
   end

   // ---- scan FSM ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= GAP;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wrap      = 1'b0;
      case (state)
         GAP: state_nxt = DRIVE;
         DRIVE: begin
            if (tick) begin
               state_nxt = GAP;
               if (idx == IDX_W'(N_DIGITS - 1)) begin
                  idx_nxt = '0;
                  wrap    = 1'b1;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: state_nxt = GAP;
      endcase
   end

   // ---- snapshot: the display only changes at a frame boundary ----
   // A LOAD on the wrap edge itself goes straight to the display, so the
   // newest value wins and nothing is left pending.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         display   <= '0;
         pending   <= '0;
         pend_flag <= 1'b0;
      end else begin
         if (bus.LOAD) pending <= bus.DIGITS;
         if (wrap && bus.LOAD) begin
            display   <= bus.DIGITS;
            pend_flag <= 1'b0;
         end else if (wrap && pend_flag) begin
            display   <= pending;
            pend_flag <= 1'b0;
         end else if (bus.LOAD) begin
            pend_flag <= 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Bit i is set when digit i and every digit above it are zero.
   // Digit 0 is never blanked.
   function automatic logic [N_DIGITS-1:0] calc_blank(input logic [4*N_DIGITS-1:0] v);
      logic seen;
      calc_blank = '0;
      seen       = 1'b0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (v[i*4 +: 4] != 4'd0) seen = 1'b1;
         calc_blank[i] = !seen;
      end
   endfunction

   logic [N_DIGITS-1:0] blank_mask;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                      blank_mask <= calc_blank('0);
      else if (wrap && bus.LOAD)    blank_mask <= calc_blank(bus.DIGITS);
      else if (wrap && pend_flag)   blank_mask <= calc_blank(pending);
   end

   always_comb begin
      cur_blank = 1'b0;
      for (int i = 0; i < N_DIGITS; i++)
         if (idx == IDX_W'(i)) cur_blank = blank_mask[i];
   end
`else
   assign cur_blank = 1'b0;
`endif

   // ---- digit select and decode ----
   always_comb begin
      cur_digit = '0;
      an_sel    = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         an_sel[i] = (idx == IDX_W'(i));
         if (idx == IDX_W'(i)) cur_digit = display[i*4 +: 4];
      end
   end

   bcd_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .digit (cur_digit),
      .segs  (dec_segs)
   );

   // ---- output registers: follow the state being entered ----
   // The outputs take the next state's values, so AN is off during the GAP
   // cycle itself. In GAP, SEGS keep their previous value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         segs_p1  <= SEG_PINS_OFF;
         an_p1    <= AN_PINS_OFF;
         frame_p1 <= 1'b0;
      end else begin
         frame_p1 <= wrap;
         if (state_nxt == DRIVE) begin
            an_p1   <= ACTIVE_LOW ? ~an_sel : an_sel;
            segs_p1 <= cur_blank ? SEG_PINS_OFF : dec_segs;
         end else begin
            an_p1   <= AN_PINS_OFF;
         end
      end
   end

   assign bus.SEGS  = segs_p1;
   assign bus.AN    = an_p1;
   assign bus.FRAME = frame_p1;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Consumer end of the BCD counter chain: takes the packed BCD digits produced by the decade counters and drives a time-multiplexed N-digit common-anode seven-segment display.
- Contains its own refresh prescaler, digit-scan counter, tear-free value snapshot, anti-ghosting blank slot and registered segment decode.
- Sits between the counter/divider blocks and the board display pins.

Parameters:
- CLK_FREQ_HZ, 50000000: input clock frequency.
- REFRESH_HZ, 1000: full-frame refresh rate (all digits once).
- N_DIGITS, 4: number of digits scanned, range 1..8.
- ACTIVE_LOW, 1: 1 means SEGS and AN are active-low at the pins; 0 means active-high.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: asynchronous, active-high reset.
- DIGITS, input, 4*N_DIGITS: packed BCD value; digit 0 is at [3:0] and is the rightmost digit.
- LOAD, input, 1: capture request for DIGITS, single-cycle or level.
- SEGS, output, 7: {g,f,e,d,c,b,a}, registered.
- AN, output, N_DIGITS: digit enables, one-hot or all-off, registered.
- FRAME, output, 1: one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Interface is fixed: one clock, CLK. Reset is asynchronous and active-high, RST.
- Reset values:
  - SEGS and AN all off (all 1s when ACTIVE_LOW=1, all 0s otherwise).
  - FRAME=0.
  - Prescaler, scan index, display register, pending register and pending flag all 0.
- Prescaler:
  - DIV = CLK_FREQ_HZ/(REFRESH_HZ*N_DIGITS), integer division. Elaboration error if DIV < 2.
  - Counts 0..DIV-1. TICK is asserted when the count equals DIV-1, and the count wraps to 0.
- Scan FSM, two states:
  - GAP: one cycle with AN all off; SEGS hold their previous value.
  - DRIVE: AN[idx] is active and SEGS = decode(display[idx]).
  - TICK in DRIVE: go to GAP and increment idx mod N_DIGITS.
  - Next cycle: GAP to DRIVE.
  - Each digit is therefore enabled for DIV-1 of every DIV cycles.
- Outputs are registered. AN/SEGS reflect the new idx one cycle after GAP, i.e. 2 cycles after TICK.
- FRAME pulses in the GAP cycle in which idx becomes 0.
- Snapshot (tear-free update):
  - LOAD=1 at a clock edge: pending <= DIGITS, pending flag set.
  - On the idx wrap to 0: if the pending flag is set, display <= pending and the flag is cleared.
  - LOAD coinciding with the wrap cycle: DIGITS goes straight to display and the flag is cleared (newest wins).
  - Repeated LOADs before a wrap overwrite pending; only the last one is shown.
- Decode (active-high form, inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10..15 show a dash (40, segment g only).
- N_DIGITS=1: GAP still occurs every DIV cycles; FRAME pulses every TICK.
- Reset asserted mid-scan: all outputs go off immediately (asynchronous). The scan restarts at idx 0 in GAP on the first edge after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When the display register is latched, compute a blank mask. Digits above the most-significant nonzero digit are blanked (SEGS all off, AN still scanned).
  - Digit 0 is never blanked, so value 0 shows "0".
  - Dash digits count as nonzero.
- Undefined: all digits are always displayed, including leading zeros.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - scan state typedef {GAP, DRIVE};
  - a function computing DIV from the parameters.
- One natural sub-module: bcd_to_seg7, a combinational nibble-to-pattern decoder with ACTIVE_LOW polarity, instantiated once on the muxed digit.

Test Plan:
Common bench settings: CLK_FREQ_HZ=16, REFRESH_HZ=1, N_DIGITS=4, so DIV=4.
1. Reset: assert RST mid-DRIVE -> SEGS=7F, AN=F, FRAME=0 before the next edge. After release, first AN=E (digit 0) appears at cycle 2+.
2. Scan order: LOAD DIGITS=16'h1234 and wait for FRAME -> sequence per 4-cycle slot:
   - AN=E shows 4 (SEGS=19 active-low);
   - AN=D shows 3 (30);
   - AN=B shows 2 (24);
   - AN=7 shows 1 (79).
   - Each slot has one AN=F gap cycle; FRAME recurs every 16 cycles.
3. Tear-free update: LOAD 16'h5678 while idx=2 -> digits 2 and 3 still show 2 and 1 until the wrap; 8,7,6,5 appear only from the next frame.
4. Invalid BCD plus simultaneous event: LOAD 16'hA0F9 exactly on the wrap cycle -> this frame shows 9, dash(3F), 0(40), dash(3F), and the pending flag is clear afterwards.
5. LEADING_ZERO_BLANK_EN defined: load 16'h0042 -> digits 3 and 2 give SEGS=7F while AN is still scanned. Load 16'h0000 -> only digit 0 shows "0" (40).
6. ACTIVE_LOW=0, N_DIGITS=1, DIV=4 -> AN toggles 1,1,1,0 per 4 cycles, FRAME pulses every 4 cycles, digit 8 gives SEGS=7F.
